normalize_unit: RTL and testbench

Iterative left-normalizer, the inverse of the shift/rotate datapath. Given a 32-bit operand, it shifts the operand left one position per cycle until it is normalized. It returns the normalized word and the shift amount that recovers it. The ALU and multiply/divide paths use it for leading-zero and redundant-sign-bit counting, sequenced through a start/done handshake.

---
 rtl/normalize_pkg.sv | 18 +
 rtl/normalize_step.sv | 46 ++++
 rtl/normalize_unit.sv | 95 +++++++++
 tb/tb_normalize_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/normalize_pkg.sv
// Shared types and constants for the iterative left-normalizer.
// Optional feature macro: NORMALIZE_FAST_EN (4-bit scan step).
package normalize_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    localparam int unsigned FAST_STEP      = 4;
    localparam int unsigned UNSIGNED_LIMIT = 32;
    localparam int unsigned SIGNED_LIMIT   = 31;

endpackage

// File: rtl/normalize_step.sv
// Combinational scan step: stop decision, step size and next working value.
// With NORMALIZE_FAST_EN defined, a 4-bit shift is taken when it cannot
// overshoot the normalization point or the count limit.
module normalize_step
    import normalize_pkg::*;
#(
    parameter int unsigned WIDTH = UNSIGNED_LIMIT,
    parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] work,
    input  logic [CW-1:0]    count,
    input  logic             mode,
    output logic             stop,
    output logic [2:0]       step,
    output logic [WIDTH-1:0] next_work
);

    localparam logic [CW-1:0] ULIM = CW'(WIDTH);
    localparam logic [CW-1:0] SLIM = CW'(WIDTH - 1);
`ifdef NORMALIZE_FAST_EN
    localparam logic [CW-1:0] ULIM_FAST = CW'(WIDTH - FAST_STEP);
    localparam logic [CW-1:0] SLIM_FAST = CW'(WIDTH - 1 - FAST_STEP);
`endif

    // Stop test followed by the shift taken when not stopping.
    always_comb begin
        stop      = 1'b0;
        step      = 3'd1;
        next_work = {work[WIDTH-2:0], 1'b0};
        if (mode == MODE_SIGNED) begin
            stop = (work[WIDTH-1] != work[WIDTH-2]) || (count == SLIM);
        end else begin
            stop = work[WIDTH-1] || (count == ULIM);
        end
`ifdef NORMALIZE_FAST_EN
        if (!stop) begin
            if (((mode == MODE_UNSIGNED) && (work[WIDTH-1 -: 4] == 4'b0000) && (count <= ULIM_FAST)) ||
                ((mode == MODE_SIGNED) && (work[WIDTH-1 -: 5] == {5{work[WIDTH-1]}}) && (count <= SLIM_FAST))) begin
                step      = 3'(FAST_STEP);
                next_work = {work[WIDTH-5:0], 4'b0000};
            end
        end
`endif
    end

endmodule

// File: rtl/normalize_unit.sv
// Iterative left-normalizer with start/done handshake; returns the
// normalized word, the shift amount and a zero-operand flag.
// Optional feature macro: NORMALIZE_FAST_EN (4-bit scan step).
module normalize_unit
    import normalize_pkg::*;
#(
    parameter int unsigned WIDTH = UNSIGNED_LIMIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [WIDTH-1:0]       a,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       norm_out,
    output logic [$clog2(WIDTH):0] shamt,
    output logic                   zero
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    count;
    logic             mode_q;
    logic             a_zero;
    logic             stop;
    logic [2:0]       step;
    logic [WIDTH-1:0] next_work;

    normalize_step #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_step (
        .work      (work),
        .count     (count),
        .mode      (mode_q),
        .stop      (stop),
        .step      (step),
        .next_work (next_work)
    );

    // Control FSM, working register, counter and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            work     <= '0;
            count    <= '0;
            mode_q   <= MODE_UNSIGNED;
            a_zero   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            norm_out <= '0;
            shamt    <= '0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SCAN;
                        busy   <= 1'b1;
                        work   <= a;
                        mode_q <= mode;
                        count  <= '0;
                        a_zero <= (a == '0);
                    end
                end
                SCAN: begin
                    if (stop) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        norm_out <= work;
                        shamt    <= count;
                        zero     <= a_zero;
                    end else begin
                        work  <= next_work;
                        count <= count + CW'(step);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_normalize_unit.sv
// Scoreboard bench for normalize_unit; latency model follows NORMALIZE_FAST_EN.
module tb_normalize_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] a;
    logic        busy;
    logic        done;
    logic [31:0] norm_out;
    logic [5:0]  shamt;
    logic        zero;

    normalize_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .a        (a),
        .busy     (busy),
        .done     (done),
        .norm_out (norm_out),
        .shamt    (shamt),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] norm;
        logic [5:0]  sh;
        logic        z;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    logic [31:0] last_norm = '0;
    logic [5:0]  last_sh = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: leading zeros (unsigned) or redundant sign bits (signed).
    function automatic int ref_shamt(input logic m, input logic [31:0] v);
        int n;
        if (!m) begin
            n = 32;
            for (int i = 0; i < 32; i++) if (v[i]) n = 31 - i;
        end else begin
            n = 31;
            for (int i = 0; i < 31; i++) if (v[i] != v[31]) n = 30 - i;
        end
        return n;
    endfunction

    function automatic int ref_lat(input int n);
`ifdef NORMALIZE_FAST_EN
        return n / 4 + n % 4 + 2;
`else
        return n + 2;
`endif
    endfunction

    // Output monitor: every done pulse must match the oldest pending request.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("norm_out", 64'(norm_out), 64'(e.norm));
                check("shamt", 64'(shamt), 64'(e.sh));
                check("zero", 64'(zero), 64'(e.z));
                check("done_cycle", 64'(cyc - e.t0), 64'(e.lat));
                last_norm = e.norm;
                last_sh   = e.sh;
            end
        end
    end

    // Issue one request from an idle unit; called at posedge+1.
    task automatic start_op(input logic m, input logic [31:0] v);
        exp_t e;
        int   n;
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("idle_before_start", 64'(busy), 64'(0));
        n      = ref_shamt(m, v);
        e.sh   = 6'(n);
        e.norm = v << n;
        e.z    = (v == 32'h0);
        e.lat  = ref_lat(n);
        e.t0   = cyc;
        sb.push_back(e);
        exp_done = done_cnt + 1;
        start = 1'b1;
        mode  = m;
        a     = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        check("busy_rise", 64'(busy), 64'(1));
        check("hold_norm", 64'(norm_out), 64'(last_norm));
        check("hold_shamt", 64'(shamt), 64'(last_sh));
    endtask

    // Bounded wait for the pending done, then confirm busy drops next cycle.
    task automatic wait_done(input string tag);
        for (int i = 0; i < 60 && done_cnt < exp_done; i++) @(posedge clk);
        check(tag, 64'(done_cnt), 64'(exp_done));
        #1;
        check("busy_fall", 64'(busy), 64'(0));
        check("done_pulse", 64'(done), 64'(0));
    endtask

    task automatic run(input logic m, input logic [31:0] v);
        start_op(m, v);
        wait_done("op_done");
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_norm", 64'(norm_out), 64'(0));
        check("rst_shamt", 64'(shamt), 64'(0));
        check("rst_zero", 64'(zero), 64'(0));

        // Directed unsigned and signed vectors, including boundaries.
        run(1'b0, 32'h8000_0000);
        run(1'b0, 32'h0001_0000);
        run(1'b0, 32'h0000_0000);
        run(1'b0, 32'h0000_0001);
        run(1'b0, 32'h0F00_0000);
        run(1'b1, 32'hFFFF_8000);
        run(1'b1, 32'hFFFF_FFFF);
        run(1'b1, 32'h0000_0000);
        run(1'b1, 32'h7FFF_FFFF);
        run(1'b1, 32'h0000_0001);
        run(1'b1, 32'hF000_0000);
        run(1'b1, 32'h0000_0010);

        // Random operands with varied leading-bit runs.
        for (int k = 0; k < 16; k++) begin
            logic [31:0] v;
            v = $urandom >> $urandom_range(0, 31);
            if (k[0]) v = ~v;
            run(1'($urandom_range(0, 1)), v);
        end

        // Start pulsed in cycle 5 of a running operation is ignored.
        start_op(1'b0, 32'h0000_0000);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 32'h1234_5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore_mid_done");

        // Start held in the DONE cycle is ignored.
        start_op(1'b1, 32'h0000_0100);
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        a     = 32'h0000_0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_in_done_busy", 64'(busy), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check("start_in_done_idle", 64'(busy), 64'(0));
        check("start_in_done_count", 64'(done_cnt), 64'(exp_done));

        // Reset mid-SCAN discards the operation and clears outputs.
        run(1'b0, 32'h0000_0003);
        start_op(1'b0, 32'h0000_0000);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        last_norm = '0;
        last_sh   = '0;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_norm", 64'(norm_out), 64'(0));
        check("midrst_shamt", 64'(shamt), 64'(0));
        check("midrst_zero", 64'(zero), 64'(0));
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_done", 64'(done_cnt), 64'(exp_done - 1));

        // Unit still works after the aborted operation.
        run(1'b0, 32'h0001_0000);

        repeat (5) @(posedge clk);
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
